// File: rtl/qdr_request_arbiter.sv
// Tag FIFO for issuer ids of outstanding reads; the head entry is visible combinationally.
// Latency: a push or pop takes effect at the next edge. The count is registered.
// Backpressure: none. The caller must not push when full unless it also pops in that cycle.
module sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop_vld && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_vld, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full with a simultaneous pop, the write lands on the slot being popped.
    // The head value is read before the edge, so the popped entry is still returned.
    always_ff @(posedge clk) begin
        if (push_vld)
            mem[wr_ptr] <= push_dat;
    end
endmodule

// N-client round-robin arbiter with independent read and write channels in front of the QDR controller.
// Latency: the grant is combinational. ram_* outputs follow 1 cycle after req&&ack. Read returns reach the client 1 cycle after ram_rd_valid.
// Backpressure: the held request waits for ack. Reads stall while the tag FIFO is full, unless a return frees a slot in the same cycle.
module qdr_request_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_BITS   = 18,
    parameter int DATA_WIDTH  = 144,
    parameter int TAG_DEPTH   = 16,
    parameter int ID_BITS     = $clog2(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CLIENTS-1:0]            client_wr_req,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0]  client_wr_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_wr_data,
    output logic [NUM_CLIENTS-1:0]            client_wr_ack,
    input  logic [NUM_CLIENTS-1:0]            client_rd_req,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0]  client_rd_addr,
    output logic [NUM_CLIENTS-1:0]            client_rd_ack,
    output logic [NUM_CLIENTS-1:0]            client_rd_valid,
    output logic [DATA_WIDTH-1:0]             client_rd_data,
    input  logic                              exclusive_en,
    input  logic [ID_BITS-1:0]                exclusive_client,
    output logic                              ram_wr_en,
    output logic [ADDR_BITS-1:0]              ram_wr_addr,
    output logic [DATA_WIDTH-1:0]             ram_wr_data,
    output logic                              ram_rd_en,
    output logic [ADDR_BITS-1:0]              ram_rd_addr,
    input  logic                              ram_rd_valid,
    input  logic [DATA_WIDTH-1:0]             ram_rd_data,
    output logic [$clog2(TAG_DEPTH):0]        outstanding,
    output logic                              err_spurious
);
    logic [ADDR_BITS-1:0]  wr_addr_arr [NUM_CLIENTS];
    logic [DATA_WIDTH-1:0] wr_data_arr [NUM_CLIENTS];
    logic [ADDR_BITS-1:0]  rd_addr_arr [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] allowed;
    logic [NUM_CLIENTS-1:0] wr_elig;
    logic [NUM_CLIENTS-1:0] rd_elig;

    logic [ID_BITS-1:0] wr_ptr;
    logic [ID_BITS-1:0] rd_ptr;
    logic [ID_BITS:0]   wr_pick;
    logic [ID_BITS:0]   rd_pick;
    logic               wr_gnt;
    logic               rd_gnt;
    logic [ID_BITS-1:0] wr_id;
    logic [ID_BITS-1:0] rd_id;

    logic               tag_pop;
    logic               tag_full;
    logic               tag_empty;
    logic [ID_BITS-1:0] tag_head;

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
        assign wr_addr_arr[i] = client_wr_addr[i*ADDR_BITS +: ADDR_BITS];
        assign wr_data_arr[i] = client_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign rd_addr_arr[i] = client_rd_addr[i*ADDR_BITS +: ADDR_BITS];
        assign allowed[i]     = !exclusive_en || (exclusive_client == ID_BITS'(i));
        assign wr_elig[i]     = client_wr_req[i] && allowed[i];
        assign rd_elig[i]     = client_rd_req[i] && allowed[i] && (!tag_full || tag_pop);
    end

    // Returns {found, id} for the first eligible client at or after ptr, wrapping modulo NUM_CLIENTS.
    function automatic logic [ID_BITS:0] rr_pick(input logic [NUM_CLIENTS-1:0] elig,
                                                 input logic [ID_BITS-1:0]     ptr);
        logic [ID_BITS:0] res;
        int               c;
        res = '0;
        for (int off = NUM_CLIENTS - 1; off >= 0; off--) begin
            c = int'(ptr) + off;
            if (c >= NUM_CLIENTS)
                c = c - NUM_CLIENTS;
            if (elig[c])
                res = {1'b1, ID_BITS'(c)};
        end
        return res;
    endfunction

    function automatic logic [ID_BITS-1:0] wrap_inc(input logic [ID_BITS-1:0] k);
        return (k == ID_BITS'(NUM_CLIENTS - 1)) ? '0 : k + 1'b1;
    endfunction

    assign wr_pick = rr_pick(wr_elig, wr_ptr);
    assign rd_pick = rr_pick(rd_elig, rd_ptr);
    assign wr_gnt  = wr_pick[ID_BITS];
    assign rd_gnt  = rd_pick[ID_BITS];
    assign wr_id   = wr_pick[ID_BITS-1:0];
    assign rd_id   = rd_pick[ID_BITS-1:0];

    assign client_wr_ack = wr_gnt ? (NUM_CLIENTS'(1) << wr_id) : '0;
    assign client_rd_ack = rd_gnt ? (NUM_CLIENTS'(1) << rd_id) : '0;

    assign tag_pop = ram_rd_valid && !tag_empty;

    // Each return is routed by the recorded issuer id, not by the current exclusive selection.
    sync_fifo #(
        .WIDTH (ID_BITS),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rd_gnt),
        .push_dat (rd_id),
        .pop_vld  (tag_pop),
        .head_dat (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (outstanding)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            ram_wr_en       <= 1'b0;
            ram_wr_addr     <= '0;
            ram_wr_data     <= '0;
            ram_rd_en       <= 1'b0;
            ram_rd_addr     <= '0;
            client_rd_valid <= '0;
            client_rd_data  <= '0;
            err_spurious    <= 1'b0;
        end else begin
            ram_wr_en <= wr_gnt;
            if (wr_gnt) begin
                ram_wr_addr <= wr_addr_arr[wr_id];
                ram_wr_data <= wr_data_arr[wr_id];
                wr_ptr      <= wrap_inc(wr_id);
            end
            ram_rd_en <= rd_gnt;
            if (rd_gnt) begin
                ram_rd_addr <= rd_addr_arr[rd_id];
                rd_ptr      <= wrap_inc(rd_id);
            end
            client_rd_valid <= tag_pop ? (NUM_CLIENTS'(1) << tag_head) : '0;
            if (tag_pop)
                client_rd_data <= ram_rd_data;
            if (ram_rd_valid && tag_empty)
                err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_qdr_request_arbiter.sv
// Directed and random stimulus for qdr_request_arbiter, checked against a queue-based reference model.
module tb_qdr_request_arbiter;
    localparam int NC = 4;
    localparam int AB = 18;
    localparam int DW = 144;
    localparam int TD = 16;
    localparam int IB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]    wr_req, rd_req;
    logic [AB-1:0]    wa [NC];
    logic [AB-1:0]    ra [NC];
    logic [DW-1:0]    wd [NC];
    logic [NC*AB-1:0] wr_addr_bus, rd_addr_bus;
    logic [NC*DW-1:0] wr_data_bus;
    logic             excl_en;
    logic [IB-1:0]    excl_cl;
    logic             rv;
    logic [DW-1:0]    rdat;

    logic [NC-1:0] wr_ack, rd_ack, cvalid;
    logic [DW-1:0] cdata, ram_wd;
    logic [AB-1:0] ram_wa, ram_ra;
    logic          ram_wen, ram_ren, err;
    logic [4:0]    outstanding;

    always_comb begin
        wr_addr_bus = '0;
        rd_addr_bus = '0;
        wr_data_bus = '0;
        for (int i = 0; i < NC; i++) begin
            wr_addr_bus[i*AB +: AB] = wa[i];
            rd_addr_bus[i*AB +: AB] = ra[i];
            wr_data_bus[i*DW +: DW] = wd[i];
        end
    end

    qdr_request_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .client_wr_req(wr_req), .client_wr_addr(wr_addr_bus), .client_wr_data(wr_data_bus),
        .client_wr_ack(wr_ack),
        .client_rd_req(rd_req), .client_rd_addr(rd_addr_bus), .client_rd_ack(rd_ack),
        .client_rd_valid(cvalid), .client_rd_data(cdata),
        .exclusive_en(excl_en), .exclusive_client(excl_cl),
        .ram_wr_en(ram_wen), .ram_wr_addr(ram_wa), .ram_wr_data(ram_wd),
        .ram_rd_en(ram_ren), .ram_rd_addr(ram_ra),
        .ram_rd_valid(rv), .ram_rd_data(rdat),
        .outstanding(outstanding), .err_spurious(err)
    );

    // Three-client instance used only for the wrap-around case.
    logic [2:0] s_wr_req, s_wr_ack, s_rd_ack, s_cvalid;
    logic [7:0] s_cdata, s_wd;
    logic [3:0] s_wa, s_ra;
    logic       s_wen, s_ren, s_err;
    logic [2:0] s_out;

    qdr_request_arbiter #(.NUM_CLIENTS(3), .ADDR_BITS(4), .DATA_WIDTH(8), .TAG_DEPTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .client_wr_req(s_wr_req), .client_wr_addr(12'h0), .client_wr_data(24'h0),
        .client_wr_ack(s_wr_ack),
        .client_rd_req(3'b0), .client_rd_addr(12'h0), .client_rd_ack(s_rd_ack),
        .client_rd_valid(s_cvalid), .client_rd_data(s_cdata),
        .exclusive_en(1'b0), .exclusive_client(2'b0),
        .ram_wr_en(s_wen), .ram_wr_addr(s_wa), .ram_wr_data(s_wd),
        .ram_rd_en(s_ren), .ram_rd_addr(s_ra),
        .ram_rd_valid(1'b0), .ram_rd_data(8'h0),
        .outstanding(s_out), .err_spurious(s_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: round-robin pointers, an id queue for in-flight reads, and the expected registered outputs.
    int            m_wptr, m_rptr, last_wk, last_rk;
    int            tagq [$];
    bit            m_err;
    bit            e_wen, e_ren;
    logic [AB-1:0] e_wa, e_ra;
    logic [DW-1:0] e_wd, e_cd;
    logic [NC-1:0] e_cv;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [NC-1:0] elig, input int ptr);
        for (int o = 0; o < NC; o++)
            if (elig[(ptr + o) % NC])
                return (ptr + o) % NC;
        return -1;
    endfunction

    function automatic logic [DW-1:0] rnd_dw();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic model_reset();
        m_wptr = 0; m_rptr = 0; m_err = 0;
        tagq.delete();
        e_wen = 0; e_ren = 0; e_wa = '0; e_ra = '0; e_wd = '0; e_cd = '0; e_cv = '0;
        last_wk = -1; last_rk = -1;
    endtask

    // Called at posedge+1 with the inputs already driven; returns at the next posedge+1.
    task automatic step();
        logic [NC-1:0] we, re;
        int  wk, rk;
        bit  pop, ok;
        pop = rv && (tagq.size() > 0);
        for (int i = 0; i < NC; i++) begin
            ok    = !excl_en || (i == int'(excl_cl));
            we[i] = wr_req[i] && ok;
            re[i] = rd_req[i] && ok && ((tagq.size() < TD) || pop);
        end
        wk = rr(we, m_wptr);
        rk = rr(re, m_rptr);
        @(negedge clk);
        chk("wr_ack", wr_ack, (wk >= 0) ? (1 << wk) : 0);
        chk("rd_ack", rd_ack, (rk >= 0) ? (1 << rk) : 0);
        chk("ram_wr_en", ram_wen, e_wen);
        chk("ram_wr_addr", ram_wa, e_wa);
        chk("ram_wr_data", ram_wd, e_wd);
        chk("ram_rd_en", ram_ren, e_ren);
        chk("ram_rd_addr", ram_ra, e_ra);
        chk("client_rd_valid", cvalid, e_cv);
        if (e_cv != 0)
            chk("client_rd_data", cdata, e_cd);
        chk("outstanding", outstanding, tagq.size());
        chk("err_spurious", err, m_err);
        e_wen = (wk >= 0);
        if (wk >= 0) begin
            e_wa = wa[wk]; e_wd = wd[wk]; m_wptr = (wk + 1) % NC;
        end
        e_ren = (rk >= 0);
        if (rk >= 0) begin
            e_ra = ra[rk]; m_rptr = (rk + 1) % NC;
        end
        e_cv = '0;
        if (rv) begin
            if (tagq.size() > 0) begin
                e_cv = NC'(1) << tagq.pop_front();
                e_cd = rdat;
            end else begin
                m_err = 1;
            end
        end
        if (rk >= 0)
            tagq.push_back(rk);
        last_wk = wk;
        last_rk = rk;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_req = '0; rd_req = '0; rv = 0; excl_en = 0; excl_cl = '0; s_wr_req = '0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_ram_wr_en", ram_wen, 0);
        chk("rst_ram_rd_en", ram_ren, 0);
        chk("rst_ram_wr_addr", ram_wa, 0);
        chk("rst_cvalid", cvalid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic drain();
        wr_req = '0; rd_req = '0; excl_en = 0;
        for (int k = 0; k < 40; k++) begin
            rv = (tagq.size() > 0);
            rdat = rnd_dw();
            step();
        end
        chk("drain_outstanding", outstanding, 0);
    endtask

    initial begin
        logic [2:0] exp3 [6];
        exp3 = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100};
        for (int i = 0; i < NC; i++) begin
            wa[i] = '0; ra[i] = '0; wd[i] = '0;
        end
        rdat = '0;
        @(posedge clk);
        #1;
        do_reset();

        // All writers busy: one grant per cycle in 0,1,2,3 order.
        for (int i = 0; i < NC; i++) begin
            wa[i] = AB'(i); wd[i] = rnd_dw();
        end
        wr_req = '1;
        for (int k = 0; k < 9; k++) step();
        wr_req = '0;
        step();

        // Single read from client 2 returning 3 cycles after issue.
        rd_req[2] = 1; ra[2] = 18'h155;
        step();
        rd_req[2] = 0;
        step(); step(); step();
        rv = 1; rdat = {18{8'hA5}};
        step();
        rv = 0;
        chk("t2_cvalid", cvalid, 4'b0100);
        chk("t2_cdata", cdata, {18{8'hA5}});
        chk("t2_outstanding", outstanding, 0);
        step();

        // Fill the tag FIFO from client 1, then check the read granted by a same-cycle return.
        rd_req[1] = 1;
        for (int k = 0; k <= TD; k++) begin
            ra[1] = AB'(k);
            step();
        end
        chk("t3_full_outstanding", outstanding, 16);
        chk("t3_full_noack", rd_ack, 0);
        rv = 1; rdat = rnd_dw();
        step();
        chk("t3_last_ack_granted", last_rk, 1);
        chk("t3_outstanding_hold", outstanding, 16);
        rv = 0;
        drain();

        // Exclusive switch with client 0 reads in flight.
        rd_req[0] = 1;
        for (int k = 0; k < 3; k++) begin
            ra[0] = AB'(k + 32);
            step();
        end
        rd_req[3] = 1; ra[3] = 18'h3ff; excl_en = 1; excl_cl = 2'd3;
        for (int k = 0; k < 4; k++) begin
            rv = (k < 3); rdat = rnd_dw();
            step();
            if (k < 3) chk("t4_return_to_c0", cvalid, 4'b0001);
            chk("t4_grant_c3", last_rk, 3);
        end
        rd_req = '0; excl_en = 0; rv = 0;
        drain();

        // Random traffic with requests held until acked.
        for (int c = 0; c < 300; c++) begin
            if (c % 60 == 0) begin
                excl_en = ($urandom % 3 == 0);
                excl_cl = IB'($urandom % NC);
            end
            for (int i = 0; i < NC; i++) begin
                if (!wr_req[i] && ($urandom % 3 == 0)) begin
                    wr_req[i] = 1; wa[i] = AB'($urandom); wd[i] = rnd_dw();
                end
                if (!rd_req[i] && ($urandom % 3 == 0)) begin
                    rd_req[i] = 1; ra[i] = AB'($urandom);
                end
            end
            rv = (tagq.size() > 0) && ($urandom % 5 < 2);
            rdat = rnd_dw();
            step();
            if (last_wk >= 0) wr_req[last_wk] = 0;
            if (last_rk >= 0) rd_req[last_rk] = 0;
        end
        drain();

        // A read is in flight when reset hits, so its late return counts as spurious.
        rd_req[1] = 1; ra[1] = 18'h7;
        step();
        rd_req[1] = 0;
        step();
        do_reset();
        rv = 1; rdat = rnd_dw();
        step();
        rv = 0;
        chk("spur_cvalid", cvalid, 0);
        chk("spur_err_set", err, 1);
        step(); step();
        chk("spur_err_held", err, 1);
        do_reset();
        chk("post_rst_err", err, 0);

        // Three clients with 0 and 2 requesting: the pointer wraps from 2 back to 0.
        s_wr_req = 3'b101;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("n3_wr_ack", s_wr_ack, exp3[k]);
            if (k > 0) chk("n3_wr_en", s_wen, 1);
            @(posedge clk);
            #1;
        end
        s_wr_req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
